program_loader: RTL and testbench

Byte-stream boot loader: the write side of the byte-addressed instruction ROM. It accepts a length-prefixed, checksummed program image over a valid/ready byte stream and writes it byte by byte, little-endian order preserved, into the instruction memory's byte array starting at `BASE_ADDR`. It holds the CPU in reset until an image has loaded and verified, then releases it. It sits between the host link (UART receiver or testbench stream) and the instruction memory write port.

---
 rtl/loader_pkg.sv | 15 +
 rtl/program_loader.sv | 168 ++++++++++++++++
 tb/tb_program_loader.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// Shared types for the program loader: FSM state encoding and image header size.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    SUM,
    DONE,
    ERR
  } loader_state_t;

  localparam int unsigned LEN_BYTES = 4;

endpackage

// File: rtl/program_loader.sv
// Boot loader: receives a length-prefixed, XOR-checksummed image over a byte stream,
// writes it into instruction memory and releases the CPU reset once it verifies.
module program_loader
  import loader_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned MEM_BYTES     = 65536,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  output logic                     in_ready,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [7:0]               mem_wdata,
  output logic                     cpu_rst,
  output logic                     busy,
  output logic                     done,
  output logic                     err_len,
  output logic                     err_sum
);

  localparam int unsigned CNT_W = $clog2(MEM_BYTES) + 1;
  localparam int unsigned IDX_W = $clog2(LEN_BYTES);

  loader_state_t r_state;
  loader_state_t w_state_nxt;

  logic [31:0]              r_len;
  logic [IDX_W-1:0]         r_len_idx;
  logic [CNT_W-1:0]         r_cnt;
  logic [7:0]               r_xsum;
  logic                     r_in_ready;
  logic                     r_mem_we;
  logic [ADDRESS_WIDTH-1:0] r_mem_addr;
  logic [7:0]               r_mem_wdata;
  logic                     r_cpu_rst;
  logic                     r_busy;
  logic                     r_done;
  logic                     r_err_len;
  logic                     r_err_sum;

  logic                     w_xfer;
  logic [31:0]              w_len_shift;
  logic [CNT_W-1:0]         w_cnt_inc;
  logic                     w_err_len_nxt;
  logic                     w_err_sum_nxt;
  logic                     w_busy_nxt;

  assign w_xfer      = in_valid && r_in_ready;
  assign w_len_shift = {in_data, r_len[31:8]};
  assign w_cnt_inc   = r_cnt + CNT_W'(1);
  assign w_busy_nxt  = (w_state_nxt == LEN) || (w_state_nxt == DATA) || (w_state_nxt == SUM);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and error-flag logic
  always_comb begin
    w_state_nxt   = r_state;
    w_err_len_nxt = r_err_len;
    w_err_sum_nxt = r_err_sum;
    case (r_state)
      IDLE: begin
        if (start) w_state_nxt = LEN;
      end
      LEN: begin
        if (w_xfer && (r_len_idx == IDX_W'(LEN_BYTES - 1))) begin
          if (w_len_shift > 32'(MEM_BYTES)) begin
            w_state_nxt   = ERR;
            w_err_len_nxt = 1'b1;
          end else if (w_len_shift == 32'd0) begin
            w_state_nxt = SUM;
          end else begin
            w_state_nxt = DATA;
          end
        end
      end
      DATA: begin
        if (w_xfer && (32'(w_cnt_inc) == r_len)) w_state_nxt = SUM;
      end
      SUM: begin
        if (w_xfer) begin
          if (in_data == r_xsum) begin
            w_state_nxt = DONE;
          end else begin
            w_state_nxt   = ERR;
            w_err_sum_nxt = 1'b1;
          end
        end
      end
      DONE, ERR: begin
        if (start) begin
          w_state_nxt   = LEN;
          w_err_len_nxt = 1'b0;
          w_err_sum_nxt = 1'b0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath and registered outputs; status outputs are decoded from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_len       <= '0;
      r_len_idx   <= '0;
      r_cnt       <= '0;
      r_xsum      <= '0;
      r_in_ready  <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_cpu_rst   <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err_len   <= 1'b0;
      r_err_sum   <= 1'b0;
    end else begin
      r_in_ready <= w_busy_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= (w_state_nxt == DONE);
      r_cpu_rst  <= (w_state_nxt != DONE);
      r_err_len  <= w_err_len_nxt;
      r_err_sum  <= w_err_sum_nxt;
      r_mem_we   <= 1'b0;

      if (r_state != LEN && w_state_nxt == LEN) r_len_idx <= '0;

      if (r_state == LEN) begin
        r_cnt  <= '0;
        r_xsum <= '0;
        if (w_xfer) begin
          r_len     <= w_len_shift;
          r_len_idx <= r_len_idx + IDX_W'(1);
        end
      end

      if (r_state == DATA && w_xfer) begin
        r_mem_we    <= 1'b1;
        r_mem_addr  <= BASE_ADDR + ADDRESS_WIDTH'(r_cnt);
        r_mem_wdata <= in_data;
        r_cnt       <= w_cnt_inc;
        r_xsum      <= r_xsum ^ in_data;
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign cpu_rst   = r_cpu_rst;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err_len   = r_err_len;
  assign err_sum   = r_err_sum;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: streams hand-built images and checks writes and status.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        cpu_rst;
  logic        busy;
  logic        done;
  logic        err_len;
  logic        err_sum;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [31:0] a;
    logic [7:0]  d;
  } wr_t;

  wr_t        wlog[$];
  logic [7:0] tb_mem[0:15];

  program_loader dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .cpu_rst  (cpu_rst),
    .busy     (busy),
    .done     (done),
    .err_len  (err_len),
    .err_sum  (err_sum)
  );

  always #5 clk = ~clk;

  // Write-port monitor: mem_we is a one-cycle pulse, so a mid-cycle sample sees it once
  always @(negedge clk) begin
    if (!rst && mem_we) begin
      wlog.push_back('{a: mem_addr, d: mem_wdata});
      tb_mem[mem_addr[3:0]] = mem_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = b;
      if (in_ready) begin
        @(posedge clk);
        ok = 1'b1;
      end
    end
    if (!ok) begin
      n_checks++;
      in_valid = 1'b0;
      $error("FAIL send_byte_timeout: observed in_ready=0 expected in_ready=1 for byte %h", b);
    end
  endtask

  // Streams an image; gap inserts one idle cycle after every byte. Ends at a negedge with in_valid low.
  task automatic send_image(input logic [7:0] img[$], input bit gap);
    foreach (img[i]) begin
      send_byte(img[i]);
      if (gap) begin
        @(negedge clk);
        in_valid = 1'b0;
      end
    end
    if (!gap) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_in_ready"}, 32'(in_ready), 32'd0);
    check({pfx, "_mem_we"},   32'(mem_we),   32'd0);
    check({pfx, "_mem_addr"}, mem_addr,      32'd0);
    check({pfx, "_mem_wdata"},32'(mem_wdata),32'd0);
    check({pfx, "_cpu_rst"},  32'(cpu_rst),  32'd1);
    check({pfx, "_busy"},     32'(busy),     32'd0);
    check({pfx, "_done"},     32'(done),     32'd0);
    check({pfx, "_err_len"},  32'(err_len),  32'd0);
    check({pfx, "_err_sum"},  32'(err_sum),  32'd0);
  endtask

  initial begin
    logic [7:0] img[$];
    logic [31:0] word;

    foreach (tb_mem[i]) tb_mem[i] = 8'h00;

    // Reset
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("rst");

    // Nominal 4-byte image
    pulse_start();
    check("nom_busy", 32'(busy), 32'd1);
    check("nom_in_ready", 32'(in_ready), 32'd1);
    img = {8'h04, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h43};
    send_image(img, 1'b0);
    check("nom_done", 32'(done), 32'd1);
    check("nom_cpu_rst", 32'(cpu_rst), 32'd0);
    check("nom_in_ready_done", 32'(in_ready), 32'd0);
    check("nom_busy_done", 32'(busy), 32'd0);
    check("nom_nwrites", 32'(wlog.size()), 32'd4);
    if (wlog.size() == 4) begin
      check("nom_w0", {wlog[0].a[23:0], wlog[0].d}, {24'd0, 8'h13});
      check("nom_w1", {wlog[1].a[23:0], wlog[1].d}, {24'd1, 8'h00});
      check("nom_w2", {wlog[2].a[23:0], wlog[2].d}, {24'd2, 8'h50});
      check("nom_w3", {wlog[3].a[23:0], wlog[3].d}, {24'd3, 8'h00});
    end
    word = {tb_mem[3], tb_mem[2], tb_mem[1], tb_mem[0]};
    check("nom_rom_word", word, 32'h0050_0013);

    // Empty image, restarted from DONE
    wlog.delete();
    pulse_start();
    check("empty_restart_cpu_rst", 32'(cpu_rst), 32'd1);
    check("empty_restart_done", 32'(done), 32'd0);
    img = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_image(img, 1'b0);
    check("empty_done", 32'(done), 32'd1);
    check("empty_cpu_rst", 32'(cpu_rst), 32'd0);
    check("empty_nwrites", 32'(wlog.size()), 32'd0);

    // Bad checksum: expected FF, sent 00
    wlog.delete();
    pulse_start();
    img = {8'h02, 8'h00, 8'h00, 8'h00, 8'hAA, 8'h55, 8'h00};
    send_image(img, 1'b0);
    check("badsum_err_sum", 32'(err_sum), 32'd1);
    check("badsum_err_len", 32'(err_len), 32'd0);
    check("badsum_cpu_rst", 32'(cpu_rst), 32'd1);
    check("badsum_done", 32'(done), 32'd0);
    check("badsum_in_ready", 32'(in_ready), 32'd0);
    check("badsum_nwrites", 32'(wlog.size()), 32'd2);
    if (wlog.size() == 2) begin
      check("badsum_w0", {wlog[0].a[23:0], wlog[0].d}, {24'd0, 8'hAA});
      check("badsum_w1", {wlog[1].a[23:0], wlog[1].d}, {24'd1, 8'h55});
    end

    // Oversize length 65537; flag visible the cycle after the 4th byte
    wlog.delete();
    pulse_start();
    check("over_err_sum_cleared", 32'(err_sum), 32'd0);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h00);
    @(negedge clk);
    check("over_err_len", 32'(err_len), 32'd1);
    check("over_in_ready", 32'(in_ready), 32'd0);
    check("over_cpu_rst", 32'(cpu_rst), 32'd1);
    in_data = 8'h77;
    @(negedge clk);
    in_valid = 1'b0;
    check("over_nwrites", 32'(wlog.size()), 32'd0);
    pulse_start();
    check("over_restart_err_len", 32'(err_len), 32'd0);
    img = {8'h01, 8'h00, 8'h00, 8'h00, 8'h5A, 8'h5A};
    send_image(img, 1'b0);
    check("over_recover_done", 32'(done), 32'd1);
    check("over_recover_nwrites", 32'(wlog.size()), 32'd1);

    // Backpressure: valid on alternate cycles, 8-byte image, checksum FF
    wlog.delete();
    pulse_start();
    img = {8'h08, 8'h00, 8'h00, 8'h00,
           8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'hFF};
    send_image(img, 1'b1);
    check("bp_done", 32'(done), 32'd1);
    check("bp_cpu_rst", 32'(cpu_rst), 32'd0);
    check("bp_nwrites", 32'(wlog.size()), 32'd8);
    if (wlog.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        check($sformatf("bp_w%0d", i), {wlog[i].a[23:0], wlog[i].d}, {24'(i), 8'(1 << i)});
      end
    end

    // Reset mid-DATA after 2 of 6 bytes
    pulse_start();
    img = {8'h06, 8'h00, 8'h00, 8'h00, 8'hA0, 8'hA1};
    foreach (img[i]) send_byte(img[i]);
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    rst = 1'b0;
    @(negedge clk);
    wlog.delete();
    pulse_start();
    img = {8'h06, 8'h00, 8'h00, 8'h00,
           8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'h01};
    send_image(img, 1'b0);
    check("midrst_done", 32'(done), 32'd1);
    check("midrst_nwrites", 32'(wlog.size()), 32'd6);
    if (wlog.size() == 6) begin
      check("midrst_first", {wlog[0].a[23:0], wlog[0].d}, {24'd0, 8'hA0});
      check("midrst_last",  {wlog[5].a[23:0], wlog[5].d}, {24'd5, 8'hA5});
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
